// File: rtl/hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_unit
//
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO
// registers of the MIPS datapath. Operands come straight from the register
// file read ports. The unit runs one shift-add (multiply) or restoring
// (divide) step per cycle on operand magnitudes, then applies a sign fix-up
// and writes HI/LO. Busy lets control stall the PC while a result is pending.
//
// Ports
//   clk      in   1   rising-edge clock
//   reset    in   1   synchronous, active-low
//   Start    in   1   launch operation selected by Op (only when not busy)
//   Op       in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   SrcA     in  32   multiplicand / dividend / MTHI-MTLO data (rs)
//   SrcB     in  32   multiplier / divisor (rt)
//   HiWrite  in   1   MTHI: HI <= SrcA (idle only)
//   LoWrite  in   1   MTLO: LO <= SrcA (idle only)
//   Hi       out 32   HI register
//   Lo       out 32   LO register
//   Busy     out  1   operation in progress
//   Done     out  1   one-cycle pulse when HI/LO take a result
//
// Latency is a fixed 33 edges from acceptance to result for every operation,
// including divide by zero.
// ---------------------------------------------------------------------------
module hilo_muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        HiWrite,
    input  logic        LoWrite,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } stateType;

    stateType    stateReg;
    logic [4:0]  countReg;
    logic        isDivReg;
    logic        negResReg;     // product / quotient must be negated
    logic        negRemReg;     // remainder takes the dividend's sign
    logic        divZeroReg;    // divisor was zero at launch
    logic [31:0] opndAReg;      // multiplicand, or dividend shifting into quotient
    logic [31:0] opndBReg;      // divisor magnitude
    logic [31:0] remReg;        // partial remainder (always < divisor)
    logic [63:0] prodReg;       // {accumulator, remaining multiplier bits}
    logic [31:0] hiReg;
    logic [31:0] loReg;
    logic        busyReg;
    logic        doneReg;

    // -----------------------------------------------------------------------
    // Launch-time operand conditioning: signed ops work on magnitudes.
    // 0x80000000 negates to itself, which is exactly its unsigned magnitude.
    // -----------------------------------------------------------------------
    logic        opSigned;
    logic        srcANeg;
    logic        srcBNeg;
    logic [31:0] srcAMag;
    logic [31:0] srcBMag;

    always_comb begin
        opSigned = ~Op[0];
        srcANeg  = opSigned & SrcA[31];
        srcBNeg  = opSigned & SrcB[31];
        srcAMag  = srcANeg ? (~SrcA + 32'd1) : SrcA;
        srcBMag  = srcBNeg ? (~SrcB + 32'd1) : SrcB;
    end

    // -----------------------------------------------------------------------
    // Per-cycle step datapath.
    // Multiply: add the multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole accumulator right; the carry
    // out of the 33-bit sum becomes the new MSB.
    // Divide: shift the next dividend bit into the remainder (33 bits wide,
    // since remainder < divisor < 2^32) and subtract when it fits.
    // -----------------------------------------------------------------------
    logic [32:0] mulSum;
    logic [32:0] divShift;
    logic [32:0] divSub;
    logic        divFits;

    always_comb begin
        mulSum   = {1'b0, prodReg[63:32]} + (prodReg[0] ? {1'b0, opndAReg} : 33'd0);
        divShift = {remReg, opndAReg[31]};
        divFits  = (divShift >= {1'b0, opndBReg});
        divSub   = divShift - {1'b0, opndBReg};
    end

    // -----------------------------------------------------------------------
    // Sign correction applied in FIX.
    // With a zero divisor every trial subtraction succeeds, so the remainder
    // ends up as the dividend magnitude; restoring its sign yields SrcA as
    // latched. Only the quotient needs forcing to all ones.
    // -----------------------------------------------------------------------
    logic [63:0] prodFinal;
    logic [31:0] quotFinal;
    logic [31:0] remFinal;

    always_comb begin
        prodFinal = negResReg ? (~prodReg + 64'd1) : prodReg;
        if (divZeroReg) begin
            quotFinal = 32'hFFFF_FFFF;
        end else begin
            quotFinal = negResReg ? (~opndAReg + 32'd1) : opndAReg;
        end
        remFinal = negRemReg ? (~remReg + 32'd1) : remReg;
    end

    // -----------------------------------------------------------------------
    // Control FSM and all state.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            stateReg   <= IDLE;
            countReg   <= 5'd0;
            isDivReg   <= 1'b0;
            negResReg  <= 1'b0;
            negRemReg  <= 1'b0;
            divZeroReg <= 1'b0;
            opndAReg   <= 32'd0;
            opndBReg   <= 32'd0;
            remReg     <= 32'd0;
            prodReg    <= 64'd0;
            hiReg      <= 32'd0;
            loReg      <= 32'd0;
            busyReg    <= 1'b0;
            doneReg    <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (Start) begin
                        // Start has priority; simultaneous MTHI/MTLO are dropped.
                        isDivReg   <= Op[1];
                        negResReg  <= srcANeg ^ srcBNeg;
                        negRemReg  <= srcANeg;
                        divZeroReg <= (SrcB == 32'd0);
                        opndAReg   <= srcAMag;
                        opndBReg   <= srcBMag;
                        remReg     <= 32'd0;
                        prodReg    <= {32'd0, srcBMag};
                        countReg   <= 5'd0;
                        busyReg    <= 1'b1;
                        stateReg   <= RUN;
                    end else begin
                        if (HiWrite) begin
                            hiReg <= SrcA;
                        end
                        if (LoWrite) begin
                            loReg <= SrcA;
                        end
                    end
                end

                RUN: begin
                    if (isDivReg) begin
                        opndAReg <= {opndAReg[30:0], divFits};
                        remReg   <= 32'(divFits ? divSub : divShift);
                    end else begin
                        prodReg  <= {mulSum, prodReg[31:1]};
                    end
                    countReg <= countReg + 5'd1;
                    if (countReg == 5'd31) begin
                        stateReg <= FIX;
                    end
                end

                FIX: begin
                    if (isDivReg) begin
                        hiReg <= remFinal;
                        loReg <= quotFinal;
                    end else begin
                        hiReg <= prodFinal[63:32];
                        loReg <= prodFinal[31:0];
                    end
                    doneReg  <= 1'b1;
                    busyReg  <= 1'b0;
                    stateReg <= IDLE;
                end

                default: begin
                    stateReg <= IDLE;
                    busyReg  <= 1'b0;
                end
            endcase
        end
    end

    assign Hi   = hiReg;
    assign Lo   = loReg;
    assign Busy = busyReg;
    assign Done = doneReg;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_hilo_muldiv_unit
//
// Directed cases for the documented corner behaviour followed by randomized
// operations, all checked against a plain-arithmetic reference model. Inputs
// are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        HiWrite;
    logic        LoWrite;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        Done;

    always #5 clk = ~clk;

    hilo_muldiv_unit dut (
        .clk     (clk),
        .reset   (reset),
        .Start   (Start),
        .Op      (Op),
        .SrcA    (SrcA),
        .SrcB    (SrcB),
        .HiWrite (HiWrite),
        .LoWrite (LoWrite),
        .Hi      (Hi),
        .Lo      (Lo),
        .Busy    (Busy),
        .Done    (Done)
    );

    int          checks = 0;
    int          errors = 0;

    // Architectural HI/LO as the bench expects them to be.
    logic [31:0] mHi;
    logic [31:0] mLo;
    // Expected result of the operation in flight.
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic [1:0]  lastOp;
    logic [31:0] lastA;
    logic [31:0] lastB;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    function automatic void refModel(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sp;
        logic signed [63:0] sq;
        logic signed [63:0] sr;
        logic [63:0]        up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            2'b00: begin
                sp = sa * sb;
                hi = sp[63:32];
                lo = sp[31:0];
            end
            2'b01: begin
                up = {32'd0, a} * {32'd0, b};
                hi = up[63:32];
                lo = up[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else if (op == 2'b10) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    hi = sr[31:0];
                    lo = sq[31:0];
                end else begin
                    hi = a % b;
                    lo = a / b;
                end
            end
        endcase
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic withLo);
        refModel(op, a, b, expHi, expLo);
        lastOp  = op;
        lastA   = a;
        lastB   = b;
        Start   = 1'b1;
        Op      = op;
        SrcA    = a;
        SrcB    = b;
        LoWrite = withLo;
        @(negedge clk);
        Start   = 1'b0;
        LoWrite = 1'b0;
        // Scramble the operand buses to prove the unit latched them.
        Op      = 2'($urandom_range(0, 3));
        SrcA    = $urandom;
        SrcB    = $urandom;
    endtask

    // Waits (bounded) for Done, checking latency, Busy span, HI/LO hold and the
    // result. Optionally injects illegal Start/MTHI/MTLO while busy.
    // Returns at the falling edge where Done is high.
    task automatic awaitResult(input string tag, input int inject);
        int cyc        = 0;
        int busyCycles = 0;
        bit changed    = 1'b0;
        while (!Done && cyc < 40) begin
            if (Busy) busyCycles++;
            if (Hi !== mHi || Lo !== mLo) changed = 1'b1;
            if (inject > 0 && cyc == inject) begin
                Start = 1'b1;
                Op    = 2'b01;
                SrcA  = 32'd3;
                SrcB  = 32'd3;
            end else if (inject > 0 && cyc == inject + 1) begin
                Start   = 1'b0;
                HiWrite = 1'b1;
                LoWrite = 1'b1;
                SrcA    = 32'h0000_AAAA;
            end else if (inject > 0 && cyc == inject + 2) begin
                HiWrite = 1'b0;
                LoWrite = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        checkVal({tag, ".done"},    64'(Done),       64'd1);
        checkVal({tag, ".latency"}, 64'(cyc),        64'd33);
        checkVal({tag, ".busyLen"}, 64'(busyCycles), 64'd33);
        checkVal({tag, ".busyEnd"}, 64'(Busy),       64'd0);
        checkVal({tag, ".held"},    64'(changed),    64'd0);
        checkVal({tag, ".hi"},      64'(Hi),         64'(expHi));
        checkVal({tag, ".lo"},      64'(Lo),         64'(expLo));
        $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h (want %h %h)",
                 tag, lastOp, lastA, lastB, Hi, Lo, expHi, expLo);
        mHi = expHi;
        mLo = expLo;
    endtask

    task automatic finishOp(input string tag);
        @(negedge clk);
        checkVal({tag, ".donePulse"}, 64'(Done), 64'd0);
        checkVal({tag, ".idle"},      64'(Busy), 64'd0);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  rOp;
        logic [31:0] rA;
        logic [31:0] rB;
        bit          sawDone;

        reset   = 1'b0;
        Start   = 1'b0;
        Op      = 2'b00;
        SrcA    = 32'd0;
        SrcB    = 32'd0;
        HiWrite = 1'b0;
        LoWrite = 1'b0;
        repeat (3) @(negedge clk);
        checkVal("reset.hi",   64'(Hi),   64'd0);
        checkVal("reset.lo",   64'(Lo),   64'd0);
        checkVal("reset.busy", 64'(Busy), 64'd0);
        checkVal("reset.done", 64'(Done), 64'd0);
        mHi   = 32'd0;
        mLo   = 32'd0;
        reset = 1'b1;
        @(negedge clk);

        // Directed arithmetic corners
        launch(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0);
        awaitResult("multu_max", 0);
        checkVal("multu_max.hiConst", 64'(Hi), 64'h0000_0001);
        checkVal("multu_max.loConst", 64'(Lo), 64'hFFFF_FFFE);
        finishOp("multu_max");

        launch(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0);
        awaitResult("mult_neg", 0);
        checkVal("mult_neg.hiConst", 64'(Hi), 64'hFFFF_FFFF);
        checkVal("mult_neg.loConst", 64'(Lo), 64'hFFFF_FFF1);
        finishOp("mult_neg");

        launch(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
        awaitResult("mult_min", 0);
        checkVal("mult_min.hiConst", 64'(Hi), 64'h4000_0000);
        checkVal("mult_min.loConst", 64'(Lo), 64'h0000_0000);
        finishOp("mult_min");

        launch(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        awaitResult("div_neg", 0);
        checkVal("div_neg.hiConst", 64'(Hi), 64'hFFFF_FFFF);
        checkVal("div_neg.loConst", 64'(Lo), 64'hFFFF_FFFD);
        finishOp("div_neg");

        launch(2'b11, 32'd100, 32'd7, 1'b0);
        awaitResult("divu", 0);
        checkVal("divu.hiConst", 64'(Hi), 64'd2);
        checkVal("divu.loConst", 64'(Lo), 64'd14);
        finishOp("divu");

        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        awaitResult("div_ovf", 0);
        checkVal("div_ovf.hiConst", 64'(Hi), 64'd0);
        checkVal("div_ovf.loConst", 64'(Lo), 64'h8000_0000);
        finishOp("div_ovf");

        // Divide by zero with illegal Start / MTHI / MTLO while busy
        launch(2'b11, 32'h0000_0064, 32'd0, 1'b0);
        awaitResult("divz_busy", 5);
        checkVal("divz_busy.hiConst", 64'(Hi), 64'h0000_0064);
        checkVal("divz_busy.loConst", 64'(Lo), 64'hFFFF_FFFF);
        finishOp("divz_busy");

        // MTHI alone, then MTHI+MTLO together
        HiWrite = 1'b1;
        SrcA    = 32'h1234_5678;
        @(negedge clk);
        HiWrite = 1'b0;
        checkVal("mthi.hi", 64'(Hi), 64'h1234_5678);
        checkVal("mthi.lo", 64'(Lo), 64'hFFFF_FFFF);
        HiWrite = 1'b1;
        LoWrite = 1'b1;
        SrcA    = 32'h0BAD_F00D;
        @(negedge clk);
        HiWrite = 1'b0;
        LoWrite = 1'b0;
        checkVal("mthilo.hi", 64'(Hi), 64'h0BAD_F00D);
        checkVal("mthilo.lo", 64'(Lo), 64'h0BAD_F00D);
        mHi = 32'h0BAD_F00D;
        mLo = 32'h0BAD_F00D;

        // Start together with MTLO: write must be dropped
        launch(2'b11, 32'd1000, 32'd10, 1'b1);
        checkVal("startWins.busy", 64'(Busy), 64'd1);
        checkVal("startWins.lo",   64'(Lo),   64'h0BAD_F00D);
        awaitResult("startWins", 0);
        finishOp("startWins");

        // Reset in the middle of an operation (sampled at E10)
        launch(2'b01, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checkVal("midReset.hi",   64'(Hi),   64'd0);
        checkVal("midReset.lo",   64'(Lo),   64'd0);
        checkVal("midReset.busy", 64'(Busy), 64'd0);
        checkVal("midReset.done", 64'(Done), 64'd0);
        mHi     = 32'd0;
        mLo     = 32'd0;
        sawDone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done || Busy) sawDone = 1'b1;
        end
        checkVal("midReset.noResult", 64'(sawDone), 64'd0);
        checkVal("midReset.hiAfter",  64'(Hi),      64'd0);

        // Restart, then chain the next op in the Done cycle
        launch(2'b01, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0);
        awaitResult("restart", 0);
        checkVal("restart.hiConst", 64'(Hi), 64'd0);
        checkVal("restart.loConst", 64'(Lo), 64'hFFFE_0001);
        launch(2'b10, 32'hFFFF_8000, 32'd3, 1'b0);
        checkVal("b2b.accepted", 64'(Busy), 64'd1);
        awaitResult("b2b", 0);
        finishOp("b2b");

        // Randomized operations against the reference model
        for (int n = 0; n < 40; n++) begin
            rOp = 2'($urandom_range(0, 3));
            rA  = pickOperand();
            rB  = pickOperand();
            if (rOp[1] && $urandom_range(0, 7) == 0) rB = 32'd0;
            launch(rOp, rA, rB, 1'b0);
            awaitResult($sformatf("rand%0d", n), 0);
            finishOp($sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Iterative multiply/divide unit with the architectural HI/LO registers for the single-cycle MIPS datapath. It sits directly downstream of the register file: it consumes ReadData1/ReadData2 as operands for MULT, MULTU, DIV and DIVU, and holds results in HI/LO for later MFHI/MFLO. It also accepts MTHI/MTLO writes. The unit asserts Busy so control can stall the PC while an operation iterates.

## Interface
- No parameters; data width fixed at 32.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low; sampled on rising clk.
- Start  input  1  launch the operation selected by Op; honoured only when Busy=0.
- Op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- SrcA  input  32  rs operand (ReadData1); multiplicand or dividend; MTHI/MTLO data.
- SrcB  input  32  rt operand (ReadData2); multiplier or divisor.
- HiWrite  input  1  MTHI: HI <= SrcA.
- LoWrite  input  1  MTLO: LO <= SrcA.
- Hi  output  32  HI register.
- Lo  output  32  LO register.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse when Hi/Lo receive a result.

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE with Start=1:
  - Latch Op.
  - Latch absolute values of the operands for signed ops, raw operands for unsigned ops.
  - Latch the result-sign flags.
  - Set count=0 and go to RUN.
- RUN: one radix-2 step per cycle.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring step producing one quotient bit and a 33-bit partial remainder.
  - count increments each cycle; after the step with count=31, go to FIX.
- FIX:
  - Apply the sign correction.
  - Write HI/LO, pulse Done, return to IDLE.
- Result rules:
  - MULT/MULTU: {Hi,Lo} = full 64-bit product. For MULT, the product is negated iff exactly one operand is negative.
  - DIV/DIVU: Lo = quotient, Hi = remainder.
  - Signed DIV: quotient truncates toward zero (negated iff operand signs differ); remainder takes the dividend's sign.
  - Divide by zero: Hi = SrcA as latched, Lo = 32'hFFFFFFFF. Full latency still applies; no exception is raised.
  - DIV 0x80000000 / 0xFFFFFFFF: Lo = 0x80000000, Hi = 0. The magnitude path produces this naturally; no special case is needed.
- MTHI/MTLO:
  - In IDLE with Start=0, HiWrite/LoWrite update HI/LO at the next edge. Both may be asserted together.
- Precedence and illegal events:
  - Start and HiWrite/LoWrite asserted together in IDLE: Start wins and the writes are dropped.
  - Start, HiWrite or LoWrite while Busy=1: ignored. Control must stall so this never occurs; the bench checks that it is dropped.
- Hi/Lo keep their old values during RUN and change only in FIX.

## Timing
- Reset (reset=0 at a rising edge):
  - Hi=0, Lo=0, Busy=0, Done=0, state=IDLE, count=0.
  - An operation in flight is aborted; its result is never written.
- Let E0 be the edge at which Start is accepted:
  - Busy=1 from after E0 until after E33.
  - RUN steps occur at E1..E32.
  - FIX edge E33: Hi/Lo updated, Done=1 for exactly the cycle after E33, Busy=0 in that same cycle.
- Back-to-back operations: a Start asserted in the Done cycle is accepted, since Busy=0. Its results appear 33 edges later.
- Latency is a fixed 33 cycles from acceptance to result for every Op and all operands, including divide by zero.
- Outputs are registered; no combinational path from inputs to Hi/Lo/Busy/Done.

## Test plan
- Reset, then MULTU with SrcA=0xFFFFFFFF, SrcB=2:
  - Busy high for 33 cycles.
  - After E33: Hi=0x00000001, Lo=0xFFFFFFFE, Done pulses once.
- MULT SrcA=0xFFFFFFFD (-3), SrcB=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
  - Then MULT 0x80000000*0x80000000 -> Hi=0x40000000, Lo=0.
- DIV divide cases:
  - DIV 0xFFFFFFF9 (-7) / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
  - DIVU 100 / 7 -> Lo=14, Hi=2.
  - DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Divide by zero and busy protection:
  - DIVU SrcA=0x64, SrcB=0 -> Hi=0x64, Lo=0xFFFFFFFF after 33 cycles.
  - During that operation, pulse Start with MULTU 3*3 and assert HiWrite with SrcA=0xAAAA; both must be ignored.
- MTHI/MTLO and precedence:
  - Idle HiWrite=1, SrcA=0x12345678 -> Hi=0x12345678 next edge, Lo unchanged.
  - Then Start=1 with LoWrite=1 -> LO write dropped; the operation runs.
- Reset mid-operation and back-to-back:
  - Start MULTU 0xFFFF*0xFFFF; drive reset=0 at E10 -> Hi=Lo=0, Busy=0, no Done.
  - Restart and complete -> Hi=0, Lo=0xFFFE0001.
  - Start the next op in the Done cycle -> accepted.
